sat_search_ctrl: RTL and testbench
==================================

Name: sat_search_ctrl

Overview:
- Sequencer for a combinational or short-pipeline 3SAT clause evaluator.
- On `start`, drives every variable assignment 0 .. 2^NVARS-1 onto the evaluator input in order, waits the evaluator latency, then samples its satisfied flag.
- Stops at the first satisfying assignment, or reports UNSAT after the last assignment.
- Sits between top-level solver control and the clause-evaluation datapath.

Parameters:
- NVARS, 4, number of boolean variables; width of the assignment bus.
- EVAL_LAT, 0, evaluator latency in cycles (0 = purely combinational); legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  pulse; begins a search when sampled high in IDLE or DONE.
- assign_out  output  NVARS  assignment presented to the evaluator.
- sat_in  input  1  evaluator result for assign_out; valid EVAL_LAT cycles after assign_out changes.
- busy  output  1  high while a search is in progress.
- done  output  1  high when a search has finished; held until the next start.
- sat  output  1  valid while done: 1 = satisfying assignment found.
- solution  output  NVARS  valid while done: the satisfying assignment, or 0 if UNSAT.

Behaviour:
- Reset: asynchronous, active-high. Clears state to IDLE and drives assign_out=0, busy=0, done=0, sat=0, solution=0, wait counter=0. Reset asserted mid-search aborts the search immediately; no result is reported.
- States:
  - IDLE: waiting for start.
  - SETTLE: waiting out the evaluator latency.
  - CHECK: sampling sat_in.
  - DONE: result held.
- IDLE:
  - start=1 at edge E0 → assign_out=0, busy=1, wait counter=EVAL_LAT.
  - Next state is SETTLE if EVAL_LAT>0, otherwise CHECK.
- SETTLE: decrements the wait counter each cycle; moves to CHECK when the counter reaches 1.
- CHECK samples sat_in at the clock edge:
  - sat_in=1 → DONE with sat=1, solution=assign_out, busy=0, done=1.
  - sat_in=0 and assign_out == all-ones → DONE with sat=0, solution=0, busy=0, done=1.
  - Otherwise → assign_out increments by 1 (NVARS-bit, no wrap reachable), counter reloads, next state is SETTLE or CHECK as above.
- Timing:
  - Each assignment k is held for exactly EVAL_LAT+1 cycles.
  - sat_in for assignment k is sampled at edge E0+(k+1)(EVAL_LAT+1); done rises after that edge.
  - Worst case (UNSAT) takes 2^NVARS·(EVAL_LAT+1) cycles.
- DONE:
  - Outputs are held and assign_out keeps its last value.
  - start=1 clears done, sat and solution at that edge and restarts the search from assign_out=0, with the same timing as from IDLE.
- start while busy is ignored; the search continues undisturbed.
- sat_in is ignored outside CHECK.
- busy and done are never high together; exactly one of IDLE/busy/done holds at any time.

Optional Feature:
- Macro: SAT_COUNT_EN.
- Defined:
  - Adds output `tried` [NVARS:0], the number of assignments evaluated in the current or last search.
  - Reset and start clear it to 0; it increments by 1 at every CHECK edge.
  - It is held in DONE (satisfying index k gives tried=k+1; UNSAT gives 2^NVARS).
- Not defined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- NVARS=4, EVAL_LAT=0, bench evaluator sat_in=(assign_out==4'b1010); start at E0 → done=1, sat=1, solution=4'b1010 after edge E0+11; busy high for exactly 11 cycles; tried=11 if SAT_COUNT_EN.
- NVARS=4, EVAL_LAT=1, same evaluator → done after edge E0+22; each assign_out value is held for exactly 2 cycles; a sat_in glitch during a SETTLE cycle is ignored.
- NVARS=4, EVAL_LAT=0, sat_in tied 0 → done after edge E0+16; sat=0, solution=0, assign_out=4'b1111; tried=16.
- Satisfying assignment 4'b0000, EVAL_LAT=2 → done after edge E0+3, solution=0, sat=1 (first-value boundary case).
- Assert reset asynchronously at E0+5 mid-search → all outputs 0 immediately, before the next edge. start pulsed while busy is ignored. start in DONE restarts from 0 and clears done at that edge.

Source files
------------

// File: rtl/sat_search_ctrl.sv
// Brute-force 3SAT search sequencer: sweeps every assignment through an external clause
// evaluator and stops at the first satisfying one. Optional macro SAT_COUNT_EN adds a `tried` counter.
module sat_search_ctrl #(
    parameter int NVARS    = 4,
    parameter int EVAL_LAT = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [NVARS-1:0] assign_out,
    input  logic             sat_in,
    output logic             busy,
    output logic             done,
    output logic             sat,
    output logic [NVARS-1:0] solution
`ifdef SAT_COUNT_EN
    ,
    output logic [NVARS:0]   tried
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] LAT      = 4'(EVAL_LAT);
    // A combinational evaluator is sampled in the very next cycle, so skip SETTLE entirely.
    localparam state_t     FIRST_ST = (EVAL_LAT == 0) ? S_CHECK : S_SETTLE;

    state_t           r_state, w_state_nxt;
    logic [NVARS-1:0] r_assign, w_assign_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_sat, w_sat_nxt;
    logic [NVARS-1:0] r_sol, w_sol_nxt;
`ifdef SAT_COUNT_EN
    logic [NVARS:0]   r_tried, w_tried_nxt;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_assign <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_sat    <= 1'b0;
            r_sol    <= '0;
`ifdef SAT_COUNT_EN
            r_tried  <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_assign <= w_assign_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_sat    <= w_sat_nxt;
            r_sol    <= w_sol_nxt;
`ifdef SAT_COUNT_EN
            r_tried  <= w_tried_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_assign_nxt = r_assign;
        w_cnt_nxt    = r_cnt;
        w_busy_nxt   = r_busy;
        w_done_nxt   = r_done;
        w_sat_nxt    = r_sat;
        w_sol_nxt    = r_sol;
`ifdef SAT_COUNT_EN
        w_tried_nxt  = r_tried;
`endif
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt  = FIRST_ST;
                    w_assign_nxt = '0;
                    w_cnt_nxt    = LAT;
                    w_busy_nxt   = 1'b1;
                    w_done_nxt   = 1'b0;
                    w_sat_nxt    = 1'b0;
                    w_sol_nxt    = '0;
`ifdef SAT_COUNT_EN
                    w_tried_nxt  = '0;
`endif
                end
            end
            S_SETTLE: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
`ifdef SAT_COUNT_EN
                w_tried_nxt = r_tried + 1'b1;
`endif
                if (sat_in) begin
                    w_state_nxt = S_DONE;
                    w_sat_nxt   = 1'b1;
                    w_sol_nxt   = r_assign;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else if (r_assign == '1) begin
                    w_state_nxt = S_DONE;
                    w_sat_nxt   = 1'b0;
                    w_sol_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt  = FIRST_ST;
                    w_assign_nxt = r_assign + 1'b1;
                    w_cnt_nxt    = LAT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign assign_out = r_assign;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sat        = r_sat;
    assign solution   = r_sol;
`ifdef SAT_COUNT_EN
    assign tried      = r_tried;
`endif

endmodule

// File: tb/tb_sat_search_ctrl.sv
// Scoreboard bench for sat_search_ctrl: three instances (EVAL_LAT 0, 1, 2) driven by
// bench-side evaluators; expected results are queued at start and checked on done.
module tb_sat_search_ctrl;

    typedef struct {
        logic       sat;
        logic [3:0] sol;
        logic [3:0] last;
        int         cyc;
        int         tried;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [2:0]      start = '0;
    logic [2:0]      sat_in;
    logic [2:0]      busy, done, sat;
    logic [2:0][3:0] assign_out, solution;
    logic [2:0][4:0] tried;
    logic [2:0][3:0] tgt = '0;
    logic [2:0]      en = '0;
    logic [2:0]      glitch = '0;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q0[$], q1[$], q2[$];
    int   bcnt[3];
    logic [2:0] busy_q = '0, done_q = '0;
    int   hold1 = 0;
    logic [3:0] last_a1 = '0;

    always #5 clk = ~clk;

    assign sat_in[0] = (en[0] && assign_out[0] == tgt[0]) || glitch[0];
    assign sat_in[1] = (en[1] && assign_out[1] == tgt[1]) || glitch[1];
    assign sat_in[2] = (en[2] && assign_out[2] == tgt[2]) || glitch[2];

    sat_search_ctrl #(.NVARS(4), .EVAL_LAT(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .assign_out(assign_out[0]),
        .sat_in(sat_in[0]), .busy(busy[0]), .done(done[0]), .sat(sat[0]),
        .solution(solution[0])
`ifdef SAT_COUNT_EN
        , .tried(tried[0])
`endif
    );

    sat_search_ctrl #(.NVARS(4), .EVAL_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .assign_out(assign_out[1]),
        .sat_in(sat_in[1]), .busy(busy[1]), .done(done[1]), .sat(sat[1]),
        .solution(solution[1])
`ifdef SAT_COUNT_EN
        , .tried(tried[1])
`endif
    );

    sat_search_ctrl #(.NVARS(4), .EVAL_LAT(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start[2]), .assign_out(assign_out[2]),
        .sat_in(sat_in[2]), .busy(busy[2]), .done(done[2]), .sat(sat[2]),
        .solution(solution[2])
`ifdef SAT_COUNT_EN
        , .tried(tried[2])
`endif
    );

`ifndef SAT_COUNT_EN
    assign tried = '0;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sb_size(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t sb_pop(input int i);
        case (i)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic exp_t mk_exp(input logic s, input int k, input int lat);
        exp_t e;
        e.sat   = s;
        e.sol   = s ? 4'(k) : 4'd0;
        e.last  = 4'(k);
        e.cyc   = (k + 1) * (lat + 1);
        e.tried = k + 1;
        return e;
    endfunction

    // Push the expectation, then pulse start for exactly one edge (called on a negedge).
    task automatic run(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int limit);
        int n = 0;
        while (!done[i] && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq($sformatf("done_seen%0d", i), 32'(done[i]), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 32'd0);
            check_eq($sformatf("%s_done%0d", tag, i), 32'(done[i]), 32'd0);
            check_eq($sformatf("%s_sat%0d", tag, i), 32'(sat[i]), 32'd0);
            check_eq($sformatf("%s_sol%0d", tag, i), 32'(solution[i]), 32'd0);
            check_eq($sformatf("%s_asg%0d", tag, i), 32'(assign_out[i]), 32'd0);
`ifdef SAT_COUNT_EN
            check_eq($sformatf("%s_tried%0d", tag, i), 32'(tried[i]), 32'd0);
`endif
        end
    endtask

    // Monitor: busy-cycle counting, hold-length check on the latency-1 instance, scoreboard pop on done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (busy[i] && !busy_q[i]) bcnt[i] = 1;
                else if (busy[i]) bcnt[i]++;
                if (done[i] && !done_q[i]) begin
                    check_eq($sformatf("sb_pending%0d", i), 32'(sb_size(i) != 0), 32'd1);
                    if (sb_size(i) != 0) begin
                        e = sb_pop(i);
                        check_eq($sformatf("sat%0d", i), 32'(sat[i]), 32'(e.sat));
                        check_eq($sformatf("solution%0d", i), 32'(solution[i]), 32'(e.sol));
                        check_eq($sformatf("assign_last%0d", i), 32'(assign_out[i]), 32'(e.last));
                        check_eq($sformatf("busy_cycles%0d", i), 32'(bcnt[i]), 32'(e.cyc));
                        check_eq($sformatf("busy_with_done%0d", i), 32'(busy[i]), 32'd0);
`ifdef SAT_COUNT_EN
                        check_eq($sformatf("tried%0d", i), 32'(tried[i]), 32'(e.tried));
`endif
                    end
                end
            end
            if (busy[1] && !busy_q[1]) begin
                hold1 = 1;
            end else if (busy[1]) begin
                if (assign_out[1] != last_a1) begin
                    check_eq("hold_lat1", 32'(hold1), 32'd2);
                    hold1 = 1;
                end else begin
                    hold1++;
                end
            end
            last_a1 = assign_out[1];
            busy_q  = busy;
            done_q  = done;
        end
    end

    initial begin
        #12;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // LAT0, satisfying 1010, with a start pulse injected while busy.
        tgt[0] = 4'b1010;
        en[0]  = 1'b1;
        run(0, mk_exp(1'b1, 10, 0));
        repeat (3) @(negedge clk);
        check_eq("busy_mid0", 32'(busy[0]), 32'd1);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 40);

        // LAT1, satisfying 1010, sat_in glitch during the SETTLE cycle of assignment 3.
        tgt[1] = 4'b1010;
        en[1]  = 1'b1;
        run(1, mk_exp(1'b1, 10, 1));
        repeat (6) @(negedge clk);
        check_eq("glitch_asg", 32'(assign_out[1]), 32'd3);
        glitch[1] = 1'b1;
        @(negedge clk);
        glitch[1] = 1'b0;
        wait_done(1, 60);

        // LAT0, unsatisfiable.
        en[0] = 1'b0;
        run(0, mk_exp(1'b0, 15, 0));
        wait_done(0, 40);

        // LAT2, first assignment satisfies.
        tgt[2] = 4'b0000;
        en[2]  = 1'b1;
        run(2, mk_exp(1'b1, 0, 2));
        wait_done(2, 20);

        // Restart from DONE clears the result at the start edge.
        tgt[0] = 4'b0101;
        en[0]  = 1'b1;
        run(0, mk_exp(1'b1, 5, 0));
        check_eq("restart_done", 32'(done[0]), 32'd0);
        check_eq("restart_sat", 32'(sat[0]), 32'd0);
        check_eq("restart_busy", 32'(busy[0]), 32'd1);
        check_eq("restart_asg", 32'(assign_out[0]), 32'd0);
        wait_done(0, 40);

        // Asynchronous reset at E0+5 of a LAT1 search; no result may appear.
        en[1] = 1'b0;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("busy_pre_rst", 32'(busy[1]), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("no_done_after_rst", 32'(done[1]), 32'd0);

        check_eq("sb_empty0", 32'(q0.size()), 32'd0);
        check_eq("sb_empty1", 32'(q1.size()), 32'd0);
        check_eq("sb_empty2", 32'(q2.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
